pio_mailbox_responder: RTL and testbench

- FPGA-side responder for the HPS↔fabric 32-bit PIO mailbox.
- HPS drives commands on the MCU PIO output port; this block decodes them and executes register ops on a local 16-bit register file, or forwards USER ops to fabric logic over a valid/ready handshake.
- Results return on the MCU PIO input port using a toggle-ack protocol.
- Sits in the top level between the soc_system PIO ports and fabric control logic, all in the clk_clk domain.

---
 rtl/pio_mbx_pkg.sv | 50 +++++
 rtl/pio_mbx_regfile.sv | 56 +++++
 rtl/pio_mailbox_responder.sv | 204 ++++++++++++++++++++
 tb/tb_pio_mailbox_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_mbx_pkg.sv
// Shared types and field positions for the HPS<->fabric PIO mailbox responder.
package pio_mbx_pkg;

  localparam int REG_W = 16;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_READ  = 3'd2,
    OP_SET   = 3'd3,
    OP_CLR   = 3'd4,
    OP_USER  = 3'd5,
    OP_ILL6  = 3'd6,
    OP_ILL7  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  // pio_cmd_i fields
  localparam int CMD_REQ_BIT  = 31;
  localparam int CMD_OP_HI    = 30;
  localparam int CMD_OP_LO    = 28;
  localparam int CMD_ADDR_HI  = 27;
  localparam int CMD_ADDR_LO  = 24;
  localparam int CMD_WDATA_HI = 15;
  localparam int CMD_WDATA_LO = 0;

  // pio_rsp_o fields
  localparam int RSP_ACK_BIT  = 31;
  localparam int RSP_BUSY_BIT = 30;
  localparam int RSP_ERR_BIT  = 29;
  localparam int RSP_TMO_BIT  = 28;
  localparam int RSP_ADDR_HI  = 27;
  localparam int RSP_ADDR_LO  = 24;
  localparam int RSP_OP_HI    = 23;
  localparam int RSP_OP_LO    = 21;
  localparam int RSP_RDATA_HI = 15;
  localparam int RSP_RDATA_LO = 0;

  function automatic logic is_reg_op(input opcode_e op);
    return (op == OP_WRITE) || (op == OP_READ) || (op == OP_SET) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/pio_mbx_regfile.sv
// NREGS x 16-bit register file: combinational read of the addressed register,
// single write port applying WRITE/SET/CLR; o_rd_data is the post-op value.
module pio_mbx_regfile
  import pio_mbx_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_we,
  input  opcode_e                i_op,
  input  logic [3:0]             i_addr,
  input  logic [REG_W-1:0]       i_data,
  output logic [REG_W-1:0]       o_rd_data,
  output logic [NREGS*REG_W-1:0] o_regs
);

  logic [REG_W-1:0] r_mem [NREGS];
  logic [REG_W-1:0] w_cur;

  function automatic logic [REG_W-1:0] apply_op(input opcode_e op,
                                                input logic [REG_W-1:0] cur,
                                                input logic [REG_W-1:0] din);
    case (op)
      OP_WRITE: return din;
      OP_SET:   return cur | din;
      OP_CLR:   return cur & ~din;
      default:  return cur;
    endcase
  endfunction

  // Out-of-range addresses read as zero; the caller never writes them.
  always_comb begin
    w_cur = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (i_addr == 4'(k)) w_cur = r_mem[k];
    end
  end

  assign o_rd_data = apply_op(i_op, w_cur, i_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NREGS; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      for (int k = 0; k < NREGS; k++) begin
        if (i_addr == 4'(k)) r_mem[k] <= o_rd_data;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign o_regs[g*REG_W +: REG_W] = r_mem[g];
  end

endmodule

// File: rtl/pio_mailbox_responder.sv
// FPGA-side responder for the HPS<->fabric 32-bit PIO mailbox (toggle req/ack).
// Optional USER-op timeout enabled by defining PIO_MBX_TIMEOUT_EN.
module pio_mailbox_responder
  import pio_mbx_pkg::*;
#(
  parameter int NREGS          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [31:0]            pio_cmd_i,
  output logic [31:0]            pio_rsp_o,
  output logic                   usr_cmd_valid_o,
  input  logic                   usr_cmd_ready_i,
  output logic [3:0]             usr_cmd_addr_o,
  output logic [REG_W-1:0]       usr_cmd_data_o,
  input  logic                   usr_rsp_valid_i,
  input  logic [REG_W-1:0]       usr_rsp_data_i,
  input  logic                   usr_rsp_err_i,
  output logic [NREGS*REG_W-1:0] regs_o
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_last_req;
  logic [31:0]      r_rsp;
  logic             r_usr_valid;

  opcode_e          r_op;
  logic [3:0]       r_addr;
  logic [REG_W-1:0] r_wdata;
  logic [REG_W-1:0] r_rdata;
  logic             r_err;

  logic             w_req_new;
  logic             w_in_range;
  logic             w_reg_we;
  logic [REG_W-1:0] w_reg_result;
  logic             w_tmo_hit;
  logic             w_tmo_bit;
  logic             w_res_load;
  logic [REG_W-1:0] w_res_rdata;
  logic             w_res_err;
  logic             w_res_tmo;
  logic             w_unused;

  assign w_req_new  = (r_state == S_IDLE) && (pio_cmd_i[CMD_REQ_BIT] != r_last_req);
  assign w_in_range = {1'b0, r_addr} < 5'(NREGS);

  pio_mbx_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .i_clk     (clk_clk),
    .i_rst_n   (reset_reset_n),
    .i_we      (w_reg_we),
    .i_op      (r_op),
    .i_addr    (r_addr),
    .i_data    (r_wdata),
    .o_rd_data (w_reg_result),
    .o_regs    (regs_o)
  );

`ifdef PIO_MBX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_tmo;
  logic             w_waiting;

  assign w_waiting = (r_state == S_WAIT_RDY) || (r_state == S_WAIT_RSP);
  assign w_tmo_hit = w_waiting && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_tmo_bit = r_tmo;
  assign w_unused  = ^pio_cmd_i[23:16];

  // Counts the cycles spent waiting on the fabric for the current USER op.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_EXEC) begin
      r_tmo_cnt <= '0;
    end else if (w_waiting) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_res_load) r_tmo <= w_res_tmo;
  end
`else
  assign w_tmo_hit = 1'b0;
  assign w_tmo_bit = 1'b0;
  assign w_unused  = ^{pio_cmd_i[23:16], w_res_tmo, 32'(TIMEOUT_CYCLES)};
`endif

  // Next state plus the result captured for the response word.
  always_comb begin
    w_state_nxt = r_state;
    w_res_load  = 1'b0;
    w_res_rdata = '0;
    w_res_err   = 1'b0;
    w_res_tmo   = 1'b0;
    w_reg_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_new) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_res_load  = 1'b1;
        w_state_nxt = S_RESP;
        if (is_reg_op(r_op)) begin
          if (w_in_range) begin
            w_res_rdata = w_reg_result;
            w_reg_we    = (r_op != OP_READ);
          end else begin
            w_res_err = 1'b1;
          end
        end else if (r_op == OP_USER) begin
          w_res_load  = 1'b0;
          w_state_nxt = S_WAIT_RDY;
        end else if (r_op != OP_NOP) begin
          w_res_err = 1'b1;
        end
      end
      S_WAIT_RDY: begin
        if (usr_cmd_ready_i) begin
          if (usr_rsp_valid_i) begin
            w_res_load  = 1'b1;
            w_res_rdata = usr_rsp_data_i;
            w_res_err   = usr_rsp_err_i;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT_RSP;
          end
        end else if (w_tmo_hit) begin
          w_res_load  = 1'b1;
          w_res_err   = 1'b1;
          w_res_tmo   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_WAIT_RSP: begin
        if (usr_rsp_valid_i) begin
          w_res_load  = 1'b1;
          w_res_rdata = usr_rsp_data_i;
          w_res_err   = usr_rsp_err_i;
          w_state_nxt = S_RESP;
        end else if (w_tmo_hit) begin
          w_res_load  = 1'b1;
          w_res_err   = 1'b1;
          w_res_tmo   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= S_IDLE;
      r_last_req  <= 1'b0;
      r_usr_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_new) begin
        r_last_req          <= pio_cmd_i[CMD_REQ_BIT];
        r_rsp[RSP_BUSY_BIT] <= 1'b1;
      end
      if ((r_state == S_EXEC) && (r_op == OP_USER)) begin
        r_usr_valid <= 1'b1;
      end else if ((r_state == S_WAIT_RDY) && (w_state_nxt != S_WAIT_RDY)) begin
        r_usr_valid <= 1'b0;
      end
      // The ack echoes last_req, which cannot move until we are back in IDLE.
      if (r_state == S_RESP) begin
        r_rsp <= {r_last_req, 1'b0, r_err, w_tmo_bit, r_addr, r_op, 5'b0, r_rdata};
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_req_new) begin
      r_op    <= opcode_e'(pio_cmd_i[CMD_OP_HI:CMD_OP_LO]);
      r_addr  <= pio_cmd_i[CMD_ADDR_HI:CMD_ADDR_LO];
      r_wdata <= pio_cmd_i[CMD_WDATA_HI:CMD_WDATA_LO];
    end
    if (w_res_load) begin
      r_rdata <= w_res_rdata;
      r_err   <= w_res_err;
    end
  end

  assign pio_rsp_o       = r_rsp;
  assign usr_cmd_valid_o = r_usr_valid;
  assign usr_cmd_addr_o  = r_addr;
  assign usr_cmd_data_o  = r_wdata;

endmodule

// File: tb/tb_pio_mailbox_responder.sv
// Directed bench for pio_mailbox_responder: table of register ops plus USER,
// queuing and reset sequences. Timeout sequence runs with PIO_MBX_TIMEOUT_EN.
module tb_pio_mailbox_responder;

  localparam int NREGS = 8;
  localparam int TMO   = 16;

  logic                clk_clk = 1'b0;
  logic                reset_reset_n;
  logic [31:0]         pio_cmd_i;
  logic [31:0]         pio_rsp_o;
  logic                usr_cmd_valid_o;
  logic                usr_cmd_ready_i;
  logic [3:0]          usr_cmd_addr_o;
  logic [15:0]         usr_cmd_data_o;
  logic                usr_rsp_valid_i;
  logic [15:0]         usr_rsp_data_i;
  logic                usr_rsp_err_i;
  logic [NREGS*16-1:0] regs_o;

  always #5 clk_clk = ~clk_clk;

  pio_mailbox_responder #(
    .NREGS          (NREGS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .pio_cmd_i       (pio_cmd_i),
    .pio_rsp_o       (pio_rsp_o),
    .usr_cmd_valid_o (usr_cmd_valid_o),
    .usr_cmd_ready_i (usr_cmd_ready_i),
    .usr_cmd_addr_o  (usr_cmd_addr_o),
    .usr_cmd_data_o  (usr_cmd_data_o),
    .usr_rsp_valid_i (usr_rsp_valid_i),
    .usr_rsp_data_i  (usr_rsp_data_i),
    .usr_rsp_err_i   (usr_rsp_err_i),
    .regs_o          (regs_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic        err;
    logic [15:0] rd;
    logic [15:0] reg3;
  } vec_t;

  vec_t vt[11];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic req_t    = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] wd);
    req_t     = ~req_t;
    pio_cmd_i = {req_t, op, addr, 8'h00, wd};
  endtask

  function automatic logic [31:0] rsp_word(input logic ack, input logic err, input logic tmo,
                                           input logic [3:0] a, input logic [2:0] op,
                                           input logic [15:0] rd);
    return {ack, 1'b0, err, tmo, a, op, 5'b0, rd};
  endfunction

  task automatic wait_valid(input string name);
    int n = 0;
    while (!usr_cmd_valid_o && n < 10) begin
      @(posedge clk_clk); #1;
      n++;
    end
    check(name, usr_cmd_valid_o, 1'b1);
  endtask

  initial begin
    logic        lg;
    logic [31:0] held;
    int          n;

    vt[0]  = '{3'd1, 4'd3,  16'hA5A5, 1'b0, 16'hA5A5, 16'hA5A5};
    vt[1]  = '{3'd3, 4'd3,  16'h000F, 1'b0, 16'hA5AF, 16'hA5AF};
    vt[2]  = '{3'd4, 4'd3,  16'h00A0, 1'b0, 16'hA50F, 16'hA50F};
    vt[3]  = '{3'd2, 4'd3,  16'hFFFF, 1'b0, 16'hA50F, 16'hA50F};
    vt[4]  = '{3'd2, 4'd15, 16'h0000, 1'b1, 16'h0000, 16'hA50F};
    vt[5]  = '{3'd7, 4'd3,  16'h0000, 1'b1, 16'h0000, 16'hA50F};
    vt[6]  = '{3'd0, 4'd3,  16'h1234, 1'b0, 16'h0000, 16'hA50F};
    vt[7]  = '{3'd1, 4'd7,  16'h1234, 1'b0, 16'h1234, 16'hA50F};
    vt[8]  = '{3'd1, 4'd8,  16'h5555, 1'b1, 16'h0000, 16'hA50F};
    vt[9]  = '{3'd3, 4'd0,  16'h8001, 1'b0, 16'h8001, 16'hA50F};
    vt[10] = '{3'd6, 4'd0,  16'hFFFF, 1'b1, 16'h0000, 16'hA50F};

    reset_reset_n   = 1'b1;
    pio_cmd_i       = '0;
    usr_cmd_ready_i = 1'b0;
    usr_rsp_valid_i = 1'b0;
    usr_rsp_data_i  = '0;
    usr_rsp_err_i   = 1'b0;
    #2 reset_reset_n = 1'b0;
    #1;
    check("reset rsp", pio_rsp_o, 32'h0);
    check("reset valid", usr_cmd_valid_o, 1'b0);
    check("reset regs", regs_o, '0);
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;

    // Register ops: busy one clock after the toggle, ack three clocks after.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk_clk); #1;
      send(vt[i].op, vt[i].addr, vt[i].wd);
      @(posedge clk_clk); #1;
      check($sformatf("v%0d busy", i), pio_rsp_o[31:30], {~req_t, 1'b1});
      @(posedge clk_clk);
      @(posedge clk_clk); #1;
      check($sformatf("v%0d rsp", i), pio_rsp_o,
            rsp_word(req_t, vt[i].err, 1'b0, vt[i].addr, vt[i].op, vt[i].rd));
      check($sformatf("v%0d reg3", i), regs_o[63:48], vt[i].reg3);
    end
    check("regs after table", regs_o,
          {16'h1234, 16'h0, 16'h0, 16'h0, 16'hA50F, 16'h0, 16'h0, 16'h8001});

    // USER with ready held low; a rsp_valid before the handshake is ignored.
    @(posedge clk_clk); #1;
    send(3'd5, 4'd2, 16'h1234);
    @(posedge clk_clk);
    @(posedge clk_clk); #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("user hold %0d", k), {usr_cmd_valid_o, usr_cmd_addr_o, usr_cmd_data_o},
            {1'b1, 4'd2, 16'h1234});
      if (k == 2) begin
        usr_rsp_valid_i = 1'b1;
        usr_rsp_data_i  = 16'hDEAD;
      end
      @(posedge clk_clk); #1;
      usr_rsp_valid_i = 1'b0;
    end
    usr_cmd_ready_i = 1'b1;
    @(posedge clk_clk); #1;
    usr_cmd_ready_i = 1'b0;
    check("user valid drop", usr_cmd_valid_o, 1'b0);
    check("user still busy", pio_rsp_o[31:30], {~req_t, 1'b1});
    repeat (2) @(posedge clk_clk);
    #1;
    usr_rsp_valid_i = 1'b1;
    usr_rsp_data_i  = 16'hBEEF;
    @(posedge clk_clk); #1;
    usr_rsp_valid_i = 1'b0;
    @(posedge clk_clk); #1;
    check("user rsp", pio_rsp_o, rsp_word(req_t, 1'b0, 1'b0, 4'd2, 3'd5, 16'hBEEF));

    // USER with rsp_valid in the same cycle as ready.
    @(posedge clk_clk); #1;
    send(3'd5, 4'd2, 16'h1234);
    wait_valid("user2 valid");
    usr_cmd_ready_i = 1'b1;
    usr_rsp_valid_i = 1'b1;
    usr_rsp_data_i  = 16'hBEEF;
    @(posedge clk_clk); #1;
    usr_cmd_ready_i = 1'b0;
    usr_rsp_valid_i = 1'b0;
    check("user2 valid drop", usr_cmd_valid_o, 1'b0);
    @(posedge clk_clk); #1;
    check("user2 rsp", pio_rsp_o, rsp_word(req_t, 1'b0, 1'b0, 4'd2, 3'd5, 16'hBEEF));

    // Double toggle while busy: the second command is lost.
    @(posedge clk_clk); #1;
    send(3'd5, 4'd4, 16'h00AA);
    wait_valid("dbl valid");
    send(3'd1, 4'd3, 16'h1111);
    @(posedge clk_clk); #1;
    send(3'd1, 4'd3, 16'h1111);
    usr_cmd_ready_i = 1'b1;
    usr_rsp_valid_i = 1'b1;
    usr_rsp_data_i  = 16'h4444;
    usr_rsp_err_i   = 1'b1;
    @(posedge clk_clk); #1;
    usr_cmd_ready_i = 1'b0;
    usr_rsp_valid_i = 1'b0;
    usr_rsp_err_i   = 1'b0;
    @(posedge clk_clk); #1;
    held = rsp_word(req_t, 1'b1, 1'b0, 4'd4, 3'd5, 16'h4444);
    check("dbl rsp", pio_rsp_o, held);
    repeat (5) @(posedge clk_clk);
    #1;
    check("dbl no second cmd", pio_rsp_o, held);
    check("dbl reg3 kept", regs_o[63:48], 16'hA50F);

    // Single toggle while busy: the queued WRITE runs right after RESP.
    @(posedge clk_clk); #1;
    send(3'd5, 4'd1, 16'h0000);
    lg = req_t;
    wait_valid("q valid");
    usr_cmd_ready_i = 1'b1;
    @(posedge clk_clk); #1;
    usr_cmd_ready_i = 1'b0;
    send(3'd1, 4'd3, 16'h7777);
    @(posedge clk_clk); #1;
    usr_rsp_valid_i = 1'b1;
    usr_rsp_data_i  = 16'h0001;
    @(posedge clk_clk); #1;
    usr_rsp_valid_i = 1'b0;
    @(posedge clk_clk); #1;
    check("q user rsp", pio_rsp_o, rsp_word(lg, 1'b0, 1'b0, 4'd1, 3'd5, 16'h0001));
    @(posedge clk_clk); #1;
    check("q busy", pio_rsp_o[31:30], {lg, 1'b1});
    @(posedge clk_clk);
    @(posedge clk_clk); #1;
    check("q write rsp", pio_rsp_o, rsp_word(req_t, 1'b0, 1'b0, 4'd3, 3'd1, 16'h7777));
    check("q reg3", regs_o[63:48], 16'h7777);

`ifdef PIO_MBX_TIMEOUT_EN
    // Timeout: ready never arrives.
    @(posedge clk_clk); #1;
    send(3'd5, 4'd9, 16'h0055);
    wait_valid("tmo valid");
    n = 0;
    while (usr_cmd_valid_o && n < 100) begin
      n++;
      @(posedge clk_clk); #1;
    end
    check("tmo valid cycles", n, TMO);
    @(posedge clk_clk); #1;
    held = rsp_word(req_t, 1'b1, 1'b1, 4'd9, 3'd5, 16'h0000);
    check("tmo rsp", pio_rsp_o, held);
    usr_rsp_valid_i = 1'b1;
    usr_rsp_data_i  = 16'h5A5A;
    @(posedge clk_clk); #1;
    usr_rsp_valid_i = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("tmo late rsp ignored", pio_rsp_o, held);
`endif

    // Reset asserted while waiting for the fabric response.
    @(posedge clk_clk); #1;
    send(3'd5, 4'd6, 16'hCAFE);
    wait_valid("rst valid");
    usr_cmd_ready_i = 1'b1;
    @(posedge clk_clk); #1;
    usr_cmd_ready_i = 1'b0;
    check("rst pre busy", pio_rsp_o[30], 1'b1);
    #2;
    reset_reset_n = 1'b0;
    pio_cmd_i     = '0;
    req_t         = 1'b0;
    #1;
    check("rst async rsp", pio_rsp_o, 32'h0);
    check("rst async valid", usr_cmd_valid_o, 1'b0);
    check("rst async regs", regs_o, '0);
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    usr_rsp_valid_i = 1'b1;
    usr_rsp_data_i  = 16'hFFFF;
    @(posedge clk_clk); #1;
    usr_rsp_valid_i = 1'b0;
    repeat (4) @(posedge clk_clk);
    #1;
    check("rst no ack", pio_rsp_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
